// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Size encodings, the FSM state type and the default word-address width.
package dmem_lsu_pkg;

    localparam int DM_AW_DEF = 6;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (is_word(sz))
            mis = (lo != 2'b00);
        else if (sz == SZ_H)
            mis = lo[0];
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request bus from the execute stage plus the word-organised data-memory bus.
// slave = the LSU view; master = the requester/memory view (execute stage or bench).
interface dmem_lsu_if
    import dmem_lsu_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
);
    // Handshake: a request transfers at a posedge where req=1 and ready=1;
    // req/we/size/uns/addr/wdata are only sampled at that edge. resp_valid
    // pulses for exactly one cycle per accepted request and cannot be stalled.
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             ready;
    logic             resp_valid;
    logic [31:0]      rdata;
    logic             err;

    logic             dm_cs;
    logic             dm_r;
    logic             dm_w;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;

    modport slave (
        input  req, we, size, uns, addr, wdata, dm_rdata,
        output ready, resp_valid, rdata, err,
        output dm_cs, dm_r, dm_w, dm_addr, dm_wdata
    );

    modport master (
        output req, we, size, uns, addr, wdata, dm_rdata,
        input  ready, resp_valid, rdata, err,
        input  dm_cs, dm_r, dm_w, dm_addr, dm_wdata
    );

endinterface

// File: rtl/dmem_lsu_lane.sv
// Byte-lane steering: load extract with sign/zero extension, store lane merge.
// Lane 0 is bits [7:0]; the half lane is lane[1], so lane[0] is ignored for halves.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] ld_word,
    input  logic [31:0] st_word,
    input  logic [15:0] st_data,
    output logic [31:0] ld_ext,
    output logic [31:0] st_merged
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel = ld_word[7:0];
        case (lane)
            2'd0:    bsel = ld_word[7:0];
            2'd1:    bsel = ld_word[15:8];
            2'd2:    bsel = ld_word[23:16];
            default: bsel = ld_word[31:24];
        endcase
        hsel = lane[1] ? ld_word[31:16] : ld_word[15:0];

        case (size)
            SZ_B:    ld_ext = {{24{~uns & bsel[7]}}, bsel};
            SZ_H:    ld_ext = {{16{~uns & hsel[15]}}, hsel};
            default: ld_ext = ld_word;
        endcase
    end

    always_comb begin
        st_merged = st_word;
        case (size)
            SZ_B: begin
                case (lane)
                    2'd0:    st_merged[7:0]   = st_data[7:0];
                    2'd1:    st_merged[15:8]  = st_data[7:0];
                    2'd2:    st_merged[23:16] = st_data[7:0];
                    default: st_merged[31:24] = st_data[7:0];
                endcase
            end
            SZ_H: begin
                if (lane[1])
                    st_merged[31:16] = st_data;
                else
                    st_merged[15:0]  = st_data;
            end
            default: st_merged = st_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for the word-organised data memory; sub-word stores use read-modify-write.
// Optional misaligned-access trap: define DMEM_LSU_MISALIGN_CHK_EN.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_lsu_if.slave bus,
    output state_t    state_dbg
);

    state_t           state_q, state_d;
    logic             we_q;
    logic             uns_q;
    logic [1:0]       size_q;
    logic [DM_AW+1:0] addr_q;
    logic [15:0]      wdata_q;
    logic [31:0]      old_q;
    logic [31:0]      wd_q;
    logic             err_q;

    logic             accept;
    logic             mis_d;
    logic [31:0]      ld_ext;
    logic [31:0]      st_merged;

    assign accept    = (state_q == IDLE) && bus.req;
    assign state_dbg = state_q;

`ifdef DMEM_LSU_MISALIGN_CHK_EN
    assign mis_d = is_misaligned(bus.size, bus.addr[1:0]);
`else
    assign mis_d = 1'b0;
`endif

    // Merge reads live dm_rdata during RD; the merged word is registered into wd_q
    // so WR drives the memory purely from flops.
    dmem_lsu_lane u_lane (
        .size      (size_q),
        .uns       (uns_q),
        .lane      (addr_q[1:0]),
        .ld_word   (old_q),
        .st_word   (bus.dm_rdata),
        .st_data   (wdata_q),
        .ld_ext    (ld_ext),
        .st_merged (st_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (mis_d)
                        state_d = DONE;
                    else if (bus.we && is_word(bus.size))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.err        = 1'b0;
        bus.rdata      = 32'h0;
        bus.dm_cs      = 1'b0;
        bus.dm_r       = 1'b0;
        bus.dm_w       = 1'b0;
        case (state_q)
            IDLE: bus.ready = 1'b1;
            RD: begin
                bus.dm_cs = 1'b1;
                bus.dm_r  = 1'b1;
            end
            WR: begin
                bus.dm_cs = 1'b1;
                bus.dm_w  = 1'b1;
            end
            default: begin
                bus.resp_valid = 1'b1;
                bus.err        = err_q;
                if (!we_q && !err_q)
                    bus.rdata = ld_ext;
            end
        endcase
    end

    assign bus.dm_addr  = addr_q[DM_AW+1:2];
    assign bus.dm_wdata = wd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= 16'h0;
            old_q   <= 32'h0;
            wd_q    <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.we;
                uns_q   <= bus.uns;
                size_q  <= bus.size;
                addr_q  <= bus.addr[DM_AW+1:0];
                wdata_q <= bus.wdata[15:0];
                err_q   <= mis_d;
                if (bus.we && is_word(bus.size))
                    wd_q <= bus.wdata;
            end
            if (state_q == RD) begin
                old_q <= bus.dm_rdata;
                if (we_q)
                    wd_q <= st_merged;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, handshake/reset sequences, and random
// ops checked against a byte-array memory model. Honours DMEM_LSU_MISALIGN_CHK_EN.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state_dbg;

    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    logic [31:0] mem [64];
    logic [7:0]  ref_b [256];
    int          n_tests = 0;
    int          n_fail = 0;

    assign bus.dm_rdata = mem[bus.dm_addr];

    always @(negedge clk) begin
        if (bus.dm_cs && bus.dm_w)
            mem[bus.dm_addr] = bus.dm_wdata;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input int lat, input logic [31:0] ew);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_lat = lat; v.exp_wd = ew;
        return v;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    // Reference: byte-addressed memory, aligned base = a - a%n, little-endian.
    task automatic ref_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] e_rdata, output logic e_err,
                          output int e_lat, output logic [31:0] e_word);
        int     n;
        int     a;
        int     base;
        int     wb;
        longint val;
        n = nbytes(sz);
        a = int'(addr & 32'hFF);
        e_rdata = 32'h0;
        e_err = 1'b0;
        e_word = 32'h0;
`ifdef DMEM_LSU_MISALIGN_CHK_EN
        if ((a % n) != 0) begin
            e_err = 1'b1;
            e_lat = 1;
            return;
        end
`endif
        base = a - (a % n);
        if (we) begin
            for (int i = 0; i < n; i++)
                ref_b[base + i] = 8'(wdata >> (8 * i));
            e_lat = (n == 4) ? 2 : 3;
        end else begin
            val = 0;
            for (int i = 0; i < n; i++)
                val = val + (longint'(ref_b[base + i]) << (8 * i));
            if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                val = val - (longint'(1) << (8 * n));
            e_rdata = 32'(val);
            e_lat = 2;
        end
        wb = base - (base % 4);
        for (int i = 0; i < 4; i++)
            e_word = e_word + (32'(ref_b[wb + i]) << (8 * i));
    endtask

    // Entered just after a negedge; returns just after the negedge following resp_valid.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rd, output logic got_err, output int got_lat,
                         output int cs_cnt, output logic [31:0] wr_data, output logic [5:0] cs_addr,
                         output logic rw_both, output logic [31:0] post_rd, output logic post_rv);
        int guard;
        guard = 0;
        got_rd = 32'h0; got_err = 1'b0; cs_cnt = 0; wr_data = 32'h0; cs_addr = 6'h0;
        rw_both = 1'b0; post_rd = 32'h0; post_rv = 1'b0;
        while (!bus.ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req = 1'b1; bus.we = we; bus.size = sz; bus.uns = uns;
        bus.addr = addr; bus.wdata = wdata;
        @(negedge clk);
        bus.req = 1'b0;
        bus.wdata = $urandom;
        got_lat = 1;
        while (!bus.resp_valid && got_lat < 10) begin
            if (bus.dm_cs) begin
                cs_cnt++;
                cs_addr = bus.dm_addr;
            end
            if (bus.dm_w) wr_data = bus.dm_wdata;
            if (bus.dm_r && bus.dm_w) rw_both = 1'b1;
            @(negedge clk);
            got_lat++;
        end
        if (!bus.resp_valid) got_lat = 99;
        got_rd = bus.rdata;
        got_err = bus.err;
        if (bus.dm_cs) cs_cnt++;
        @(negedge clk);
        post_rd = bus.rdata;
        post_rv = bus.resp_valid;
    endtask

    task automatic run_and_check(input string name, input logic we, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e_rd, e_word, g_rd, g_wd, p_rd;
        logic        e_err, g_err, g_both, p_rv;
        logic [5:0]  g_ca;
        int          e_lat, g_lat, g_cs;
        ref_op(we, sz, uns, addr, wdata, e_rd, e_err, e_lat, e_word);
        do_op(we, sz, uns, addr, wdata, g_rd, g_err, g_lat, g_cs, g_wd, g_ca, g_both, p_rd, p_rv);
        check({name, "_rdata"}, g_rd, e_rd);
        check({name, "_err"}, 32'(g_err), 32'(e_err));
        check({name, "_lat"}, g_lat, e_lat);
        check({name, "_rw_excl"}, 32'(g_both), 32'h0);
        check({name, "_pulse"}, {31'h0, p_rv} | p_rd, 32'h0);
        if (e_err) begin
            check({name, "_no_cs"}, g_cs, 0);
        end else begin
            check({name, "_dm_addr"}, 32'(g_ca), 32'(addr[7:2]));
            if (we) check({name, "_dm_wdata"}, g_wd, e_word);
        end
    endtask

    initial begin
        logic [31:0] v, e_rd, e_word, g_rd, g_wd, p_rd;
        logic        e_err, g_err, g_both, p_rv;
        logic [5:0]  g_ca;
        int          e_lat, g_lat, g_cs;
        int          acc, pulses, last, gap_bad, low, rd_bad, rv_seen;

        for (int w = 0; w < 64; w++) begin
            v = $urandom;
            mem[w] = v;
            for (int b = 0; b < 4; b++) ref_b[4 * w + b] = 8'(v >> (8 * b));
        end
        bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_W; bus.uns = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_strobes", {29'h0, bus.dm_cs, bus.dm_r, bus.dm_w}, 32'h0);
        check("rst_dm_addr", 32'(bus.dm_addr), 32'h0);
        check("rst_dm_wdata", bus.dm_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        vt[0]  = mk(1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 32'hDEADBEEF);
        vt[1]  = mk(0, SZ_W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 32'h0);
        vt[2]  = mk(1, SZ_W, 0, 32'h10, 32'h11223344, 32'h0, 2, 32'h11223344);
        vt[3]  = mk(1, SZ_B, 0, 32'h12, 32'h000000AA, 32'h0, 3, 32'h11AA3344);
        vt[4]  = mk(0, SZ_W, 0, 32'h10, 32'h0, 32'h11AA3344, 2, 32'h0);
        vt[5]  = mk(1, SZ_W, 0, 32'h10, 32'h80FF7F01, 32'h0, 2, 32'h80FF7F01);
        vt[6]  = mk(0, SZ_B, 0, 32'h12, 32'h0, 32'hFFFFFFFF, 2, 32'h0);
        vt[7]  = mk(0, SZ_B, 1, 32'h13, 32'h0, 32'h00000080, 2, 32'h0);
        vt[8]  = mk(0, SZ_H, 0, 32'h10, 32'h0, 32'h00007F01, 2, 32'h0);
        vt[9]  = mk(0, SZ_H, 0, 32'h12, 32'h0, 32'hFFFF80FF, 2, 32'h0);
        vt[10] = mk(0, SZ_H, 1, 32'h12, 32'h0, 32'h000080FF, 2, 32'h0);
        vt[11] = mk(0, SZ_W, 0, 32'hFFFFFF10, 32'h0, 32'h80FF7F01, 2, 32'h0);
        vt[12] = mk(1, SZ_H, 0, 32'h12, 32'h1234BEEF, 32'h0, 3, 32'hBEEF7F01);
        vt[13] = mk(0, SZ_W, 0, 32'h10, 32'h0, 32'hBEEF7F01, 2, 32'h0);
        vt[14] = mk(0, 2'b11, 0, 32'h10, 32'h0, 32'hBEEF7F01, 2, 32'h0);
        vt[15] = mk(1, SZ_W, 0, 32'hFC, 32'hCAFEF00D, 32'h0, 2, 32'hCAFEF00D);
        vt[16] = mk(0, SZ_B, 1, 32'hFF, 32'h0, 32'h000000CA, 2, 32'h0);
        for (int i = 0; i < 17; i++) begin
            ref_op(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, e_rd, e_err, e_lat, e_word);
            do_op(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
                  g_rd, g_err, g_lat, g_cs, g_wd, g_ca, g_both, p_rd, p_rv);
            check($sformatf("vec%0d_rdata", i), g_rd, vt[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'h0);
            check($sformatf("vec%0d_lat", i), g_lat, vt[i].exp_lat);
            check($sformatf("vec%0d_dm_addr", i), 32'(g_ca), 32'(vt[i].addr[7:2]));
            if (vt[i].we) check($sformatf("vec%0d_dm_wdata", i), g_wd, vt[i].exp_wd);
        end

        // Misaligned accesses (trap or forced alignment depending on build)
        run_and_check("mis_lw", 0, SZ_W, 0, 32'h11, 32'h0);
        run_and_check("mis_lh", 0, SZ_H, 0, 32'h13, 32'h0);
        run_and_check("mis_sw", 1, SZ_W, 0, 32'h22, 32'h5A5A1234);
        run_and_check("mis_chk_lw", 0, SZ_W, 0, 32'h20, 32'h0);

        // Back-to-back: req held high for three word loads
        ref_op(0, SZ_W, 0, 32'h10, 32'h0, e_rd, e_err, e_lat, e_word);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = SZ_W; bus.uns = 1'b0; bus.addr = 32'h10;
        acc = 0; pulses = 0; last = -100; gap_bad = 0; low = 0; rd_bad = 0;
        for (int c = 0; c < 14; c++) begin
            if (bus.resp_valid) begin
                if (pulses > 0 && (c - last) != 3) gap_bad++;
                if (bus.rdata !== e_rd) rd_bad++;
                last = c;
                pulses++;
            end
            if (!bus.ready) low++;
            if (bus.ready && bus.req) acc++;
            @(negedge clk);
            if (acc == 3) bus.req = 1'b0;
        end
        check("b2b_accepts", acc, 3);
        check("b2b_pulses", pulses, 3);
        check("b2b_gap", gap_bad, 0);
        check("b2b_ready_low", low, 6);
        check("b2b_rdata", rd_bad, 0);

        // Reset during WR before the write negedge
        bus.req = 1'b1; bus.we = 1'b1; bus.size = SZ_W; bus.addr = 32'h20;
        bus.wdata = ~{ref_b[35], ref_b[34], ref_b[33], ref_b[32]};
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check("rst_wr_state", 32'(state_dbg), 32'(WR));
        check("rst_wr_dm_w_pre", 32'(bus.dm_w), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_strobes", {29'h0, bus.dm_cs, bus.dm_r, bus.dm_w}, 32'h0);
        check("rst_wr_ready", 32'(bus.ready), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid) rv_seen++;
        end
        check("rst_wr_no_resp", rv_seen, 0);
        check("rst_wr_ready_after", 32'(bus.ready), 32'h1);
        check("rst_wr_mem", mem[8], {ref_b[35], ref_b[34], ref_b[33], ref_b[32]});
        run_and_check("rst_wr_readback", 0, SZ_W, 0, 32'h20, 32'h0);

        // Random ops against the byte-array model
        for (int i = 0; i < 150; i++) begin
            run_and_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that drives the CPU's word-organised data memory: CS, read strobe, write strobe, 6-bit word address, write data; takes combinational read data back.
- Takes byte-addressed load/store requests from the execute stage over a req/ready handshake.
- Performs byte, halfword and word accesses; sub-word stores use read-modify-write.
- Returns load data, sign- or zero-extended, with a one-cycle resp_valid pulse.

Parameters:
- DM_AW, 6, memory word-address width; the byte address uses bits [DM_AW+1:2], and higher bits are ignored (wrap modulo 2^(DM_AW+2) bytes).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1=store, 0=load.
- size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
- uns  in  1  loads only: 1=zero-extend, 0=sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- ready  out  1  1 only in IDLE.
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- rdata  out  32  extended load data; valid while resp_valid=1, 0 otherwise.
- err  out  1  misaligned-access flag; qualified by resp_valid.
- dm_cs  out  1  memory chip select.
- dm_r  out  1  memory read enable.
- dm_w  out  1  memory write enable; memory writes on negedge clk.
- dm_addr  out  DM_AW  word address.
- dm_wdata  out  32  word write data.
- dm_rdata  in  32  combinational memory read data.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, ready=1, resp_valid=0, rdata=0, err=0, dm_cs=dm_r=dm_w=0, dm_addr=0, dm_wdata=0.
- States: IDLE, RD, WR, DONE.
- Acceptance: in IDLE, req=1 latches we/size/uns/addr/wdata at posedge.
  - Load, or sub-word store -> RD.
  - Word store -> WR.
  - Inputs are ignored outside IDLE.
- RD: dm_cs=1, dm_r=1, dm_addr from latched addr. At the next posedge dm_rdata is captured into the old-word register.
  - Load -> DONE.
  - Sub-word store -> WR.
- WR: dm_cs=1, dm_w=1. dm_addr and dm_wdata are driven from registers only, so they are stable at the mid-cycle negedge write.
  - dm_wdata = merged word: the selected lane(s) take wdata[7:0] or wdata[15:0]; other lanes keep the old word. Word store uses wdata directly.
  - Next state: DONE.
- DONE: resp_valid=1 for exactly one cycle; rdata holds the load result (0 for stores). Next state: IDLE, ready=1.
- Lane select: byte lane = addr[1:0]; half lane = addr[1]. Lane 0 = bits [7:0] (little-endian).
- Latency from acceptance edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Throughput: back-to-back req is accepted the cycle after DONE, i.e. one op every 3 or 4 cycles.
- dm_cs/dm_r/dm_w are 0 in IDLE and DONE. dm_r and dm_w are never both 1.
- Reset mid-operation clears all memory strobes immediately. A WR interrupted before its negedge performs no write. No resp_valid is issued for the aborted op.

Optional Feature:
- Macro: DMEM_LSU_MISALIGN_CHK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->DONE with no memory strobes.
  - DONE then gives err=1, rdata=0.
- Undefined:
  - Low misaligned bits are forced to the aligned lane (half: addr[0] ignored; word: addr[1:0] ignored).
  - err is constant 0.

Decomposition:
- Package dmem_lsu_pkg holds: size encodings SZ_B, SZ_H, SZ_W; the state enum (IDLE/RD/WR/DONE); the DM_AW default.
- One combinational sub-module, dmem_lsu_lane:
  - lane extract + sign/zero extension for loads;
  - lane merge for stores.
- The FSM stays in dmem_lsu.

Test Plan:
- Word store then load: store addr=0x10 wdata=0xDEADBEEF; then load word addr=0x10 -> dm_addr=4, resp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
- Byte RMW: mem[4]=0x11223344; sb addr=0x12 wdata=0xAA -> RD then WR, dm_wdata=0x11AA3344, resp_valid 3 cycles after accept.
- Sign vs zero extension: mem[4]=0x80FF7F01.
  - lb addr=0x12 uns=0 -> 0xFFFFFFFF.
  - lbu addr=0x13 -> 0x00000080.
  - lh addr=0x10 uns=0 -> 0x00007F01.
  - lh addr=0x12 uns=0 -> 0xFFFF80FF.
- Handshake: hold req=1 continuously for 3 word loads -> ready low from accept to end of DONE; exactly 3 resp_valid pulses, 3 cycles apart.
- Reset mid-WR: assert rst_n=0 during WR before negedge -> dm_w drops immediately, mem[addr] unchanged on readback, ready=1 after release.
- Misaligned (with DMEM_LSU_MISALIGN_CHK_EN): lw addr=0x11 -> no dm_cs pulse, resp_valid with err=1, rdata=0. Without the macro -> reads word 4, err=0.
